uart_byte_transmitter: RTL and testbench
========================================

# uart_byte_transmitter

Serial transmit back end of the host UART link. It consumes the byte stream produced by the word-to-byte unpacker: an 8-bit byte plus a one-cycle transmit strobe, four strobes per 32-bit GPU word, MSB byte first. Bytes are buffered in a small FIFO, because the unpacker has no backpressure and strobes every second cycle. Each buffered byte is then serialized on a single TX line as 8N1 frames, with no idle gap between consecutive frames.

## Interface
Parameters:
- CLOCK_DIVIDER, default 868: iClock cycles per UART bit. Must be ≥ 2.
- FIFO_DEPTH, default 8: byte FIFO entries. Must be a power of two, ≥ 4.

Ports:
- iClock  in  1  single system clock; all logic on its rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iUartTx8  in  `UART_WORD_OUT_SZ (8)  byte to send; sampled only when iByteTransmit = 1.
- iByteTransmit  in  1  one-cycle write strobe; each high cycle is one byte.
- oTx  out  1  serial line, registered; idle level 1.
- oBusy  out  1  high while the FIFO is non-empty or a frame is in progress.
- oFifoFull  out  1  FIFO occupancy = FIFO_DEPTH.
- oOverflow  out  1  sticky flag: a byte was dropped because the FIFO was full. Cleared only by reset.

## Operation
- Reset (asynchronous assert, sync release) sets: oTx=1, oBusy=0, oFifoFull=0, oOverflow=0, FIFO empty, state IDLE. A frame in progress is aborted; the line returns high immediately.
- FIFO write: on iByteTransmit=1 and not full, write iUartTx8 at the write pointer; the pointer advances mod FIFO_DEPTH.
  - Full with strobe: the byte is dropped and oOverflow is set, even if a pop occurs in the same cycle.
- Occupancy counter width is clog2(FIFO_DEPTH)+1. A simultaneous write and pop while not full leaves occupancy unchanged.
- Serializer FSM states:
  - IDLE: oTx=1. If FIFO non-empty: pop, load the shift register, bit counter=0, go to START.
  - START: oTx=0 for CLOCK_DIVIDER cycles, then go to DATA.
  - DATA: oTx=shift[0], LSB first. Shift after each CLOCK_DIVIDER cycles; after 8 bits go to STOP.
  - STOP: oTx=1 for CLOCK_DIVIDER cycles. On the last cycle:
    - FIFO non-empty: pop, load, go to START (back-to-back, no gap).
    - FIFO empty: go to IDLE.
- Baud counter: width clog2(CLOCK_DIVIDER). It counts 0..CLOCK_DIVIDER-1 and wraps to 0 on each bit boundary. It is held at 0 in IDLE.
- oBusy = (occupancy≠0) | (state≠IDLE), registered.

## Timing
- Strobe in cycle 0 into an empty FIFO with the FSM idle:
  - Occupancy is 1 in cycle 1 and the pop happens in cycle 1.
  - oTx falls in cycle 2 (start bit).
  - Frame length is exactly 10·CLOCK_DIVIDER cycles, from cycle 2 through cycle 1+10·CLOCK_DIVIDER.
- oBusy rises in cycle 1. It falls one cycle after the last STOP cycle if no data is pending.
- Unpacker cadence is one strobe every 2 cycles. One 32-bit word (4 bytes) never overflows the FIFO for any legal CLOCK_DIVIDER.
- Strobes in consecutive cycles are legal, and each high cycle is one byte.
- oFifoFull reflects occupancy one cycle after the write edge.

## Structure
- Definitions.v holds:
  - `UART_WORD_OUT_SZ (already present).
  - New defines UARTTX_IDLE, UARTTX_START, UARTTX_DATA, UARTTX_STOP.
  - Default `UART_CLOCK_DIVIDER.
- One sub-module, uart_tx_fifo. It is a synchronous single-clock byte FIFO: parameter DEPTH, write/read enables, full/empty, occupancy, same async active-high reset.
- The top level contains the serializer FSM, baud counter, bit counter, shift register and flags.

## Test plan
Each item is stimulus → required response.

- Single byte: CLOCK_DIVIDER=4, FIFO_DEPTH=8, strobe 0xA5 at cycle 0.
  - oTx is high until cycle 2, then the bit sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles (cycles 2–41).
  - oBusy is 1 in cycles 1–41 and 0 from cycle 42.
- Word stream: unpacker-style strobes of 0x12, 0x34, 0x56, 0x78 at cycles 0, 2, 4, 6.
  - Four contiguous frames in that byte order, 160 cycles total, from cycle 2.
  - No idle cycle between frames; oOverflow stays 0.
- Overflow: 10 strobes in cycles 0–9 with values 0x00–0x09.
  - oFifoFull=1 from cycle 9.
  - 0x09 is dropped and oOverflow=1 from cycle 10 onward.
  - Exactly nine frames 0x00–0x08 are sent, then IDLE.
- Simultaneous pop and write: FIFO holds 1 byte, and a strobe coincides with the final STOP cycle.
  - Occupancy is unchanged.
  - The next frame starts with no gap.
  - The new byte is sent after it, in order.
- Reset mid-frame: assert iReset asynchronously during DATA bit 3 of 0xFF with 3 bytes queued.
  - oTx=1 with no clock edge.
  - After release: oBusy=0, oFifoFull=0, oOverflow=0, and no frames are emitted.
- Wrap-around: send 20 bytes (0x00–0x13) at the unpacker cadence, with a CLOCK_DIVIDER slow enough to keep 2–5 bytes buffered.
  - All 20 bytes are received in order by a bench UART monitor across pointer wrap.

Source files
------------

// File: rtl/uart_byte_transmitter_pkg.sv
// Shared definitions for the UART byte transmitter: byte width, default
// baud divider and serializer state encoding.
package uart_byte_transmitter_pkg;

    localparam int unsigned UART_WORD_OUT_SZ   = 8;
    localparam int unsigned UART_CLOCK_DIVIDER = 868;

    typedef enum logic [1:0] {
        UARTTX_IDLE  = 2'd0,
        UARTTX_START = 2'd1,
        UARTTX_DATA  = 2'd2,
        UARTTX_STOP  = 2'd3
    } uarttx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with occupancy counter; writes while full and
// reads while empty are ignored.
module uart_tx_fifo
    import uart_byte_transmitter_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = UART_WORD_OUT_SZ
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_fire, rd_fire;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign wr_fire   = wr_en_i & ~full_o;
    assign rd_fire   = rd_en_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_fire ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_byte_transmitter.sv
// 8N1 serial transmitter fed by a byte FIFO; consecutive buffered bytes are
// sent as back-to-back frames with no idle gap.
module uart_byte_transmitter
    import uart_byte_transmitter_pkg::*;
#(
    parameter int unsigned CLOCK_DIVIDER = UART_CLOCK_DIVIDER,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                        iClock,
    input  logic                        iReset,
    input  logic [UART_WORD_OUT_SZ-1:0] iUartTx8,
    input  logic                        iByteTransmit,
    output logic                        oTx,
    output logic                        oBusy,
    output logic                        oFifoFull,
    output logic                        oOverflow
);

    localparam int unsigned BAUD_W = $clog2(CLOCK_DIVIDER);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_DIVIDER - 1);

    uarttx_state_e               state_q, state_d;
    logic [BAUD_W-1:0]           baud_q, baud_d;
    logic [2:0]                  bit_q, bit_d;
    logic [UART_WORD_OUT_SZ-1:0] shift_q, shift_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;
    logic                        ovf_q, ovf_d;
    logic                        pop, bit_end;
    logic                        fifo_full, fifo_empty;
    logic [UART_WORD_OUT_SZ-1:0] fifo_rdata;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_WORD_OUT_SZ)
    ) u_fifo (
        .clk_i     (iClock),
        .rst_i     (iReset),
        .wr_en_i   (iByteTransmit),
        .wr_data_i (iUartTx8),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            UARTTX_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    bit_d   = '0;
                    state_d = UARTTX_START;
                end
            end
            UARTTX_START: if (bit_end) state_d = UARTTX_DATA;
            UARTTX_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[UART_WORD_OUT_SZ-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = UARTTX_STOP;
                end
            end
            UARTTX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        bit_d   = '0;
                        state_d = UARTTX_START;
                    end else begin
                        state_d = UARTTX_IDLE;
                    end
                end
            end
            default: state_d = UARTTX_IDLE;
        endcase

        // Line level is registered from next-state so oTx lines up with state_q.
        case (state_d)
            UARTTX_START: tx_d = 1'b0;
            UARTTX_DATA:  tx_d = shift_d[0];
            default:      tx_d = 1'b1;
        endcase

        // Next occupancy is non-zero iff the FIFO holds data or takes a write;
        // a pop always moves the FSM out of IDLE, so it cannot clear busy.
        busy_d = (state_d != UARTTX_IDLE) | ~fifo_empty | iByteTransmit;
        ovf_d  = ovf_q | (iByteTransmit & fifo_full);
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= UARTTX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oTx       = tx_q;
    assign oBusy     = busy_q;
    assign oFifoFull = fifo_full;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Directed bench for uart_byte_transmitter with a free-running 8N1 line monitor.
module tb_uart_byte_transmitter;

    localparam int unsigned D     = 4;
    localparam int unsigned DEPTH = 8;

    logic       iClock = 1'b0;
    logic       iReset = 1'b1;
    logic [7:0] iUartTx8 = '0;
    logic       iByteTransmit = 1'b0;
    logic       oTx, oBusy, oFifoFull, oOverflow;

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  mon_q[$];
    int unsigned mon_t[$];
    int          frame_err = 0;

    uart_byte_transmitter #(
        .CLOCK_DIVIDER (D),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .iClock        (iClock),
        .iReset        (iReset),
        .iUartTx8      (iUartTx8),
        .iByteTransmit (iByteTransmit),
        .oTx           (oTx),
        .oBusy         (oBusy),
        .oFifoFull     (oFifoFull),
        .oOverflow     (oOverflow)
    );

    always #5 iClock = ~iClock;
    always @(posedge iClock) cyc <= cyc + 1;

    // Line monitor: start detected at first low negedge, bits sampled one cycle into each bit.
    initial begin
        logic [7:0]  b;
        int unsigned ts;
        forever begin
            @(negedge iClock);
            if (oTx === 1'b0) begin
                ts = cyc;
                repeat (D + 1) @(negedge iClock);
                b[0] = oTx;
                for (int i = 1; i < 8; i++) begin
                    repeat (D) @(negedge iClock);
                    b[i] = oTx;
                end
                repeat (D) @(negedge iClock);
                if (oTx !== 1'b1) frame_err++;
                mon_q.push_back(b);
                mon_t.push_back(ts);
            end
        end
    end

    task automatic next_cycle;
        @(posedge iClock);
        #1;
    endtask

    task automatic do_reset;
        iReset = 1'b1;
        iByteTransmit = 1'b0;
        repeat (3) next_cycle;
        iReset = 1'b0;
        next_cycle;
    endtask

    task automatic mon_clear;
        mon_q.delete();
        mon_t.delete();
        frame_err = 0;
    endtask

    task automatic test_reset;
        do_reset;
        vectors++; if (oTx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", oTx); end
        vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", oBusy); end
        vectors++; if (oFifoFull !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", oFifoFull); end
        vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", oOverflow); end
    endtask

    task automatic test_single_byte;
        logic [9:0] fr;
        logic       exp_tx, exp_busy;
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 46; k++) begin
            if (k > 0) next_cycle;
            exp_tx   = (k >= 2 && k <= 41) ? fr[(k - 2) / 4] : 1'b1;
            exp_busy = (k >= 1 && k <= 41);
            vectors++; if (oTx !== exp_tx) begin miscompares++; $display("FAIL single_tx cycle %0d got %b want %b", k, oTx, exp_tx); end
            vectors++; if (oBusy !== exp_busy) begin miscompares++; $display("FAIL single_busy cycle %0d got %b want %b", k, oBusy, exp_busy); end
            iByteTransmit = (k == 0);
            iUartTx8 = 8'hA5;
        end
        vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL single_ovf got %b want 0", oOverflow); end
    endtask

    task automatic test_word_stream;
        logic [7:0]  bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        int unsigned t0;
        logic [7:0]  got;
        int unsigned gt;
        mon_clear;
        t0 = cyc;
        for (int k = 0; k < 170; k++) begin
            if (k > 0) next_cycle;
            iByteTransmit = (k < 8) && (k % 2 == 0);
            iUartTx8 = (k < 8) ? bytes[k / 2] : 8'h00;
        end
        vectors++; if (mon_q.size() != 4) begin miscompares++; $display("FAIL word_count got %0d want 4", mon_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 8'hxx;
            gt  = (i < mon_t.size()) ? mon_t[i] : 0;
            vectors++; if (got !== bytes[i]) begin miscompares++; $display("FAIL word_byte%0d got %h want %h", i, got, bytes[i]); end
            vectors++; if (gt != t0 + 2 + 40 * i) begin miscompares++; $display("FAIL word_start%0d got %0d want %0d", i, gt - t0, 2 + 40 * i); end
        end
        vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL word_ovf got %b want 0", oOverflow); end
        vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL word_busy_end got %b want 0", oBusy); end
        vectors++; if (frame_err != 0) begin miscompares++; $display("FAIL word_stopbit got %0d errors want 0", frame_err); end
    endtask

    task automatic test_overflow;
        int unsigned t0;
        logic [7:0]  got;
        int unsigned gt;
        do_reset;
        mon_clear;
        t0 = cyc;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) next_cycle;
            if (k == 8) begin
                vectors++; if (oFifoFull !== 1'b0) begin miscompares++; $display("FAIL ovf_full_c8 got %b want 0", oFifoFull); end
            end
            if (k == 9) begin
                vectors++; if (oFifoFull !== 1'b1) begin miscompares++; $display("FAIL ovf_full_c9 got %b want 1", oFifoFull); end
                vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL ovf_flag_c9 got %b want 0", oOverflow); end
            end
            if (k == 10) begin
                vectors++; if (oOverflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag_c10 got %b want 1", oOverflow); end
            end
            if (k == 42) begin
                vectors++; if (oFifoFull !== 1'b0) begin miscompares++; $display("FAIL ovf_full_c42 got %b want 0", oFifoFull); end
            end
            iByteTransmit = (k < 10);
            iUartTx8 = 8'(k);
        end
        vectors++; if (mon_q.size() != 9) begin miscompares++; $display("FAIL ovf_count got %0d want 9", mon_q.size()); end
        for (int i = 0; i < 9; i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 8'hxx;
            gt  = (i < mon_t.size()) ? mon_t[i] : 0;
            vectors++; if (got !== 8'(i)) begin miscompares++; $display("FAIL ovf_byte%0d got %h want %h", i, got, 8'(i)); end
            vectors++; if (gt != t0 + 2 + 40 * i) begin miscompares++; $display("FAIL ovf_start%0d got %0d want %0d", i, gt - t0, 2 + 40 * i); end
        end
        vectors++; if (oOverflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", oOverflow); end
        vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL ovf_busy_end got %b want 0", oBusy); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] vals [4] = '{8'hFF, 8'h11, 8'h22, 8'h33};
        int         lows;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) next_cycle;
            iByteTransmit = (k < 4);
            iUartTx8 = (k < 4) ? vals[k] : 8'h00;
        end
        vectors++; if (oOverflow !== 1'b1) begin miscompares++; $display("FAIL rst_pre_ovf got %b want 1", oOverflow); end
        vectors++; if (oBusy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy got %b want 1", oBusy); end
        #2 iReset = 1'b1;
        #1;
        vectors++; if (oTx !== 1'b1) begin miscompares++; $display("FAIL rst_async_tx got %b want 1", oTx); end
        vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy got %b want 0", oBusy); end
        vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL rst_async_ovf got %b want 0", oOverflow); end
        next_cycle;
        next_cycle;
        iReset = 1'b0;
        next_cycle;
        vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL rst_post_busy got %b want 0", oBusy); end
        vectors++; if (oFifoFull !== 1'b0) begin miscompares++; $display("FAIL rst_post_full got %b want 0", oFifoFull); end
        vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL rst_post_ovf got %b want 0", oOverflow); end
        // Second abort while the line is low (data bit 0 of 0x00).
        for (int k = 0; k < 9; k++) begin
            if (k > 0) next_cycle;
            iByteTransmit = (k == 0);
            iUartTx8 = 8'h00;
        end
        vectors++; if (oTx !== 1'b0) begin miscompares++; $display("FAIL rst_low_pre_tx got %b want 0", oTx); end
        #2 iReset = 1'b1;
        #1;
        vectors++; if (oTx !== 1'b1) begin miscompares++; $display("FAIL rst_low_async_tx got %b want 1", oTx); end
        next_cycle;
        next_cycle;
        iReset = 1'b0;
        next_cycle;
        repeat (60) next_cycle;
        mon_clear;
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            next_cycle;
            if (oTx !== 1'b1) lows++;
        end
        vectors++; if (lows != 0) begin miscompares++; $display("FAIL rst_quiet_line got %0d low cycles want 0", lows); end
        vectors++; if (mon_q.size() != 0) begin miscompares++; $display("FAIL rst_no_frames got %0d want 0", mon_q.size()); end
        vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL rst_quiet_busy got %b want 0", oBusy); end
    endtask

    task automatic test_simul_pop_write;
        logic [7:0]  bytes [3] = '{8'h3C, 8'hC3, 8'h5A};
        int unsigned t0;
        logic [7:0]  got;
        int unsigned gt;
        do_reset;
        mon_clear;
        t0 = cyc;
        for (int k = 0; k < 130; k++) begin
            if (k > 0) next_cycle;
            if (k == 41 || k == 42) begin
                vectors++; if (dut.u_fifo.count_q !== 4'd1) begin miscompares++; $display("FAIL simul_occ_c%0d got %0d want 1", k, dut.u_fifo.count_q); end
            end
            iByteTransmit = (k == 0 || k == 1 || k == 41);
            iUartTx8 = (k == 0) ? bytes[0] : (k == 1) ? bytes[1] : bytes[2];
        end
        vectors++; if (mon_q.size() != 3) begin miscompares++; $display("FAIL simul_count got %0d want 3", mon_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 8'hxx;
            gt  = (i < mon_t.size()) ? mon_t[i] : 0;
            vectors++; if (got !== bytes[i]) begin miscompares++; $display("FAIL simul_byte%0d got %h want %h", i, got, bytes[i]); end
            vectors++; if (gt != t0 + 2 + 40 * i) begin miscompares++; $display("FAIL simul_start%0d got %0d want %0d", i, gt - t0, 2 + 40 * i); end
        end
        vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL simul_busy_end got %b want 0", oBusy); end
    endtask

    task automatic test_wraparound;
        logic [7:0] got;
        int         w;
        mon_clear;
        for (int k = 0; k < 1100; k++) begin
            if (k > 0) next_cycle;
            w = k / 150;
            iByteTransmit = (w < 5) && (k % 150 < 8) && (k % 2 == 0);
            iUartTx8 = 8'(w * 4 + (k % 150) / 2);
        end
        vectors++; if (mon_q.size() != 20) begin miscompares++; $display("FAIL wrap_count got %0d want 20", mon_q.size()); end
        for (int i = 0; i < 20; i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 8'hxx;
            vectors++; if (got !== 8'(i)) begin miscompares++; $display("FAIL wrap_byte%0d got %h want %h", i, got, 8'(i)); end
        end
        vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL wrap_ovf got %b want 0", oOverflow); end
        vectors++; if (frame_err != 0) begin miscompares++; $display("FAIL wrap_stopbit got %0d errors want 0", frame_err); end
        vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL wrap_busy_end got %b want 0", oBusy); end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_word_stream;
        test_overflow;
        test_reset_mid_frame;
        test_simul_pop_write;
        test_wraparound;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
